intto_fp_array: RTL and testbench
=================================

Name: intto_fp_array

Overview:
- Four-lane signed-integer to floating-point converter array; the inverse of the fpto_int_array path in the SMC vector datapath.
- Takes a 128-bit vector of four 32-bit words plus a 5-bit CRU micro-instruction.
- Converts INT32/INT16 to FP32/FP16 with round-to-nearest-even (RNE) and drives a registered 128-bit result toward the DR.
- Two-stage pipeline; accepts one instruction per cycle.

Parameters:
- LANES, 4, number of 32-bit lanes; the output width is LANES*32.
- PIPE_STAGES, 2, fixed latency in cycles; only 2 is supported, and any other value is an elaboration error.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- dvr_inttofp_s_in  in  128  source vector; lane 0 = [127:96], lane 3 = [31:0].
- cru_inttofp_in  in  5  micro-instruction, bits as follows:
  - [4] inst_vld.
  - [3] src_prec: 1 = INT32, 0 = INT16.
  - [2] dst_prec: 1 = FP32, 0 = FP16.
  - [1] src_pos: INT16 source half, 1 = [31:16].
  - [0] dst_pos: FP16 dest half, 1 = [31:16].
- dr_inttofp_d_out  out  128  registered result vector, same lane order as the input.
- dr_inttofp_vld_out  out  1  high for one cycle when dr_inttofp_d_out is updated.

Behaviour:
- Reset:
  - Sampled on a clk rising edge while rst=1.
  - Clears dr_inttofp_d_out to 0, dr_inttofp_vld_out to 0 and all pipeline valid bits.
  - An in-flight instruction is discarded and never produces vld_out.
- Latency and throughput:
  - An instruction sampled with inst_vld=1 at edge N updates d_out and pulses vld_out=1 after edge N+2.
  - Back-to-back issue is allowed every cycle. There is no stall and no backpressure.
- Hold: when inst_vld=0 is sampled, that slot is a bubble. d_out holds its previous value and vld_out=0 two cycles later.
- Stage 1 (sign, magnitude, leading-zero count) and Stage 2 (normalize, RNE round, exponent adjust, pack) feed the output register.
- Source selection:
  - src_prec=1: the whole word is INT32.
  - src_prec=0: the INT16 is taken from the half selected by src_pos and sign-extended.
- Destination placement:
  - dst_prec=1: FP32 fills the word.
  - dst_prec=0 with src_prec=1: FP16 goes to the half selected by dst_pos; the other half is 0.
  - dst_prec=0 with src_prec=1 applies to INT32 to FP16.
- Paired mode (src_prec=0 and dst_prec=0):
  - Both INT16 halves of each word convert independently, high to high and low to low. This gives 8 results.
  - src_pos and dst_pos are ignored.
- Exactness and rounding:
  - INT16 to FP32 is always exact.
  - All other combinations round RNE. Ties go to an even mantissa.
  - Rounding carry-out increments the exponent.
- Zero → +0 (0x00000000 or 0x0000). -0 is never produced.
- Most negative values: -2^31 → 0xCF000000; -32768 → FP32 0xC7000000 or FP16 0xF800.
- FP16 overflow (rounded magnitude > 65504, i.e. |x| ≥ 65520) → ±INF (0x7C00/0xFC00) by default.
- No NaN and no denormal outputs are possible.
- Reset and issue in the same cycle: reset wins and the instruction is dropped.

Optional Feature:
- Macro: INTTOFP_SAT_EN.
- Defined: FP16 overflow saturates to ±max finite (0x7BFF/0xFBFF) instead of ±INF. FP32 is unaffected, since it cannot overflow.
- Undefined: IEEE RNE overflow to ±INF as described above.

Decomposition:
- Package intto_fp_pkg holds:
  - CRU bit-index constants (VLD=4, SRC_PREC=3, DST_PREC=2, SRC_POS=1, DST_POS=0).
  - FP32/FP16 bias, exponent and mantissa widths.
  - FP16 max-finite and INF encodings.
- Sub-module intto_fp_lane:
  - One converter taking a 32-bit signed magnitude source and dst_prec, with its Stage 1 / Stage 2 registers.
  - The array instantiates 8 of them, 2 per word. The high-half lane is used only in paired mode.
  - The array owns source mux, placement mux, valid pipeline and output register.

Test Plan:
1. INT32→FP32, words {1, -1, 123, -456}, cru=5'b11100 → after 2 edges d_out={3F800000, BF800000, 42F60000, C3E40000}, vld_out 1 cycle.
2. INT32→FP16 low, cru=5'b11000:
   - Words {2049, 2051, 65504, 65520} → {00006800, 00006802, 00007BFF, 00007C00}.
   - With INTTOFP_SAT_EN the last word → 00007BFF; -70000 → 0000FC00 (FBFF with SAT_EN).
3. INT16 high→FP32, cru=5'b10110, words {0001_xxxx, FFFE_xxxx, 7FFF_xxxx, 8000_xxxx} → {3F800000, C0000000, 46FFFE00, C7000000}.
4. Paired INT16→FP16, cru=5'b10000, words {00020001, 7FFF8000, 0, FFFF0003} → {40003C00, 7800F800, 00000000, BC004200}.
5. INT32 edge values and tie, cru=5'b11100:
   - Words {0, 80000000, 7FFFFFFF, 01000001} → {00000000, CF000000, 4F000000, 4B800000}.
   - Issue on 3 consecutive cycles → 3 consecutive vld_out pulses, results in order.
6. Control:
   - A vld=0 slot → d_out unchanged, vld_out=0.
   - rst=1 for one cycle right after a valid issue → no vld_out and d_out=0.
   - A new instruction after reset completes normally at N+2.

Source files
------------

// File: rtl/intto_fp_pkg.sv
// Shared constants for the signed-integer to floating-point converter array:
// CRU micro-instruction bit positions, IEEE field geometry and FP16 overflow encodings.
package intto_fp_pkg;

    localparam int CRU_VLD      = 4;
    localparam int CRU_SRC_PREC = 3;
    localparam int CRU_DST_PREC = 2;
    localparam int CRU_SRC_POS  = 1;
    localparam int CRU_DST_POS  = 0;

    localparam int FP32_BIAS  = 127;
    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int FP16_BIAS  = 15;
    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;

    // Magnitude parts only; the sign bit is prepended by the lane.
    localparam logic [14:0] FP16_MAX_MAG = 15'h7BFF;
    localparam logic [14:0] FP16_INF_MAG = 15'h7C00;

    // Control that travels alongside the data to steer the output placement.
    typedef struct packed {
        logic src_prec;
        logic dst_prec;
        logic dst_pos;
    } place_t;

    // Leading-zero count of a 32-bit value; returns 32 for zero.
    function automatic logic [5:0] lzc32(input logic [31:0] v);
        logic [5:0] n;
        logic       found;
        n     = 6'd32;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 6'(31 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/intto_fp_lane.sv
// One signed INT32 -> FP32/FP16 converter with RNE rounding: stage 1 takes sign, magnitude
// and leading-zero count, stage 2 normalizes, rounds and packs. Macro INTTOFP_SAT_EN clamps FP16 overflow.
module intto_fp_lane
    import intto_fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] src,
    input  logic        dst_prec,
    output logic [31:0] res
);

`ifdef INTTOFP_SAT_EN
    localparam logic [14:0] OVF_MAG = FP16_MAX_MAG;
`else
    localparam logic [14:0] OVF_MAG = FP16_INF_MAG;
`endif

    logic        sign_d;
    logic [31:0] mag_d;
    logic [5:0]  lzc_d;

    logic        sign_q;
    logic [31:0] mag_q;
    logic [5:0]  lzc_q;
    logic        prec_q;

    always_comb begin
        sign_d = src[31];
        mag_d  = sign_d ? (~src + 32'd1) : src;
        lzc_d  = lzc32(mag_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q <= 1'b0;
            mag_q  <= '0;
            lzc_q  <= '0;
            prec_q <= 1'b0;
        end else begin
            sign_q <= sign_d;
            mag_q  <= mag_d;
            lzc_q  <= lzc_d;
            prec_q <= dst_prec;
        end
    end

    // norm drops the leading one, which is the hidden bit in both formats.
    logic [30:0]           norm;
    logic                  up32;
    logic                  up16;
    logic [FP32_MAN_W:0]   r32;
    logic [FP16_MAN_W:0]   r16;
    logic [7:0]            exp32;
    logic [5:0]            exp16;
    logic                  ovf16;
    logic [14:0]           mag16;
    logic [31:0]           fp32;
    logic [15:0]           fp16;
    logic [31:0]           res_d;

    always_comb begin
        norm  = 31'(mag_q << lzc_q);
        up32  = norm[30-FP32_MAN_W] & ((|norm[29-FP32_MAN_W:0]) | norm[31-FP32_MAN_W]);
        up16  = norm[30-FP16_MAN_W] & ((|norm[29-FP16_MAN_W:0]) | norm[31-FP16_MAN_W]);
        r32   = {1'b0, norm[30 -: FP32_MAN_W]} + {{FP32_MAN_W{1'b0}}, up32};
        r16   = {1'b0, norm[30 -: FP16_MAN_W]} + {{FP16_MAN_W{1'b0}}, up16};
        // A rounding carry leaves the mantissa at zero and bumps the exponent.
        exp32 = 8'(FP32_BIAS + 31) - {2'b00, lzc_q} + {7'd0, r32[FP32_MAN_W]};
        exp16 = 6'(FP16_BIAS + 31) - lzc_q + {5'd0, r16[FP16_MAN_W]};
        ovf16 = exp16 >= 6'((1 << FP16_EXP_W) - 1);
        mag16 = ovf16 ? OVF_MAG : {exp16[FP16_EXP_W-1:0], r16[FP16_MAN_W-1:0]};
        fp32  = {sign_q, exp32[FP32_EXP_W-1:0], r32[FP32_MAN_W-1:0]};
        fp16  = {sign_q, mag16};
        res_d = '0;
        if (mag_q != '0) begin
            res_d = prec_q ? fp32 : {16'h0000, fp16};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res <= '0;
        end else begin
            res <= res_d;
        end
    end

endmodule

// File: rtl/intto_fp_array.sv
// Four-word signed-integer to floating-point converter array with registered output.
// Two converter lanes per word; build with INTTOFP_SAT_EN to saturate FP16 overflow.
module intto_fp_array
    import intto_fp_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANES*32-1:0]   dvr_inttofp_s_in,
    input  logic [4:0]            cru_inttofp_in,
    output logic [LANES*32-1:0]   dr_inttofp_d_out,
    output logic                  dr_inttofp_vld_out
);

    generate
        if (PIPE_STAGES != 2) begin : g_bad_pipe_stages
            $error("intto_fp_array: only PIPE_STAGES == 2 is supported");
        end
    endgenerate

    logic   inst_vld;
    logic   src_pos;
    place_t place_d;
    place_t place1;
    place_t place2;
    logic   vld1;
    logic   vld2;

    always_comb begin
        inst_vld         = cru_inttofp_in[CRU_VLD];
        src_pos          = cru_inttofp_in[CRU_SRC_POS];
        place_d.src_prec = cru_inttofp_in[CRU_SRC_PREC];
        place_d.dst_prec = cru_inttofp_in[CRU_DST_PREC];
        place_d.dst_pos  = cru_inttofp_in[CRU_DST_POS];
    end

    // Valid and placement control ride alongside the lane stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld1   <= 1'b0;
            vld2   <= 1'b0;
            place1 <= '0;
            place2 <= '0;
        end else begin
            vld1   <= inst_vld;
            vld2   <= vld1;
            place1 <= place_d;
            place2 <= place1;
        end
    end

    logic [LANES*32-1:0] placed;

    for (genvar w = 0; w < LANES; w++) begin : g_word
        logic [31:0] word;
        logic [15:0] half;
        logic [31:0] lo_src;
        logic [31:0] hi_src;
        logic [31:0] lo_res;
        logic [31:0] hi_res;
        logic [15:0] unused_hi;

        // Paired mode (both precisions narrow) always maps low half to the low lane.
        assign word   = dvr_inttofp_s_in[(LANES-1-w)*32 +: 32];
        assign half   = (src_pos && place_d.dst_prec) ? word[31:16] : word[15:0];
        assign lo_src = place_d.src_prec ? word : {{16{half[15]}}, half};
        assign hi_src = {{16{word[31]}}, word[31:16]};

        intto_fp_lane u_lo (
            .clk      (clk),
            .rst      (rst),
            .src      (lo_src),
            .dst_prec (place_d.dst_prec),
            .res      (lo_res)
        );

        intto_fp_lane u_hi (
            .clk      (clk),
            .rst      (rst),
            .src      (hi_src),
            .dst_prec (1'b0),
            .res      (hi_res)
        );

        assign unused_hi = hi_res[31:16];

        assign placed[(LANES-1-w)*32 +: 32] =
            place2.dst_prec  ? lo_res :
            !place2.src_prec ? {hi_res[15:0], lo_res[15:0]} :
            place2.dst_pos   ? {lo_res[15:0], 16'h0000} :
                               {16'h0000, lo_res[15:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dr_inttofp_d_out   <= '0;
            dr_inttofp_vld_out <= 1'b0;
        end else begin
            dr_inttofp_vld_out <= vld2;
            if (vld2) begin
                dr_inttofp_d_out <= placed;
            end
        end
    end

endmodule

// File: tb/tb_intto_fp_array.sv
// Directed table-driven bench for intto_fp_array; expectations follow INTTOFP_SAT_EN when defined.
module tb_intto_fp_array;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] din;
    logic [4:0]   cru;
    logic [127:0] d_out;
    logic         vld_out;

    always #5 clk = ~clk;

    intto_fp_array dut (
        .clk                (clk),
        .rst                (rst),
        .dvr_inttofp_s_in   (din),
        .cru_inttofp_in     (cru),
        .dr_inttofp_d_out   (d_out),
        .dr_inttofp_vld_out (vld_out)
    );

`ifdef INTTOFP_SAT_EN
    localparam logic [15:0] OVF_P = 16'h7BFF;
    localparam logic [15:0] OVF_N = 16'hFBFF;
`else
    localparam logic [15:0] OVF_P = 16'h7C00;
    localparam logic [15:0] OVF_N = 16'hFC00;
`endif

    typedef struct packed {
        logic [127:0] din;
        logic [4:0]   cru;
        logic [127:0] exp;
    } vec_t;

    localparam int NVEC = 10;
    vec_t tbl [NVEC];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one instruction and verify the pulse lands exactly two edges after sampling.
    task automatic run_vec(input int idx);
        @(negedge clk);
        din = tbl[idx].din;
        cru = tbl[idx].cru;
        @(negedge clk);
        cru = 5'b00000;
        check($sformatf("vec%0d vld_after_N", idx), {127'd0, vld_out}, 128'd0);
        @(negedge clk);
        check($sformatf("vec%0d vld_after_N1", idx), {127'd0, vld_out}, 128'd0);
        @(negedge clk);
        check($sformatf("vec%0d vld_after_N2", idx), {127'd0, vld_out}, 128'd1);
        check($sformatf("vec%0d d_out", idx), d_out, tbl[idx].exp);
        @(negedge clk);
        check($sformatf("vec%0d vld_drop", idx), {127'd0, vld_out}, 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{din: {32'h00000001, 32'hFFFFFFFF, 32'h0000007B, 32'hFFFFFE38}, cru: 5'b11100,
                   exp: {32'h3F800000, 32'hBF800000, 32'h42F60000, 32'hC3E40000}};
        tbl[1] = '{din: {32'h00000801, 32'h00000803, 32'h0000FFE0, 32'h0000FFF0}, cru: 5'b11000,
                   exp: {32'h00006800, 32'h00006802, 32'h00007BFF, 16'h0000, OVF_P}};
        tbl[2] = '{din: {32'hFFFEEE90, 32'h00000001, 32'hFFFFFFFF, 32'h7FFFFFFF}, cru: 5'b11001,
                   exp: {OVF_N, 16'h0000, 32'h3C000000, 32'hBC000000, OVF_P, 16'h0000}};
        tbl[3] = '{din: {32'hFFFF8000, 32'h00000000, 32'h0000FFEF, 32'h80000000}, cru: 5'b11000,
                   exp: {32'h0000F800, 32'h00000000, 32'h00007BFF, 16'h0000, OVF_N}};
        tbl[4] = '{din: {32'h0001ABCD, 32'hFFFE1234, 32'h7FFF0000, 32'h8000FFFF}, cru: 5'b10110,
                   exp: {32'h3F800000, 32'hC0000000, 32'h46FFFE00, 32'hC7000000}};
        tbl[5] = '{din: {32'h12340005, 32'h00008000, 32'hFFFFFFFF, 32'h55550000}, cru: 5'b10100,
                   exp: {32'h40A00000, 32'hC7000000, 32'hBF800000, 32'h00000000}};
        tbl[6] = '{din: {32'h00020001, 32'h7FFF8000, 32'h00000000, 32'hFFFF0003}, cru: 5'b10000,
                   exp: {32'h40003C00, 32'h7800F800, 32'h00000000, 32'hBC004200}};
        tbl[7] = '{din: {32'h00020001, 32'h7FFF8000, 32'h00000000, 32'hFFFF0003}, cru: 5'b10011,
                   exp: {32'h40003C00, 32'h7800F800, 32'h00000000, 32'hBC004200}};
        tbl[8] = '{din: {32'h00000000, 32'h80000000, 32'h7FFFFFFF, 32'h01000001}, cru: 5'b11100,
                   exp: {32'h00000000, 32'hCF000000, 32'h4F000000, 32'h4B800000}};
        tbl[9] = '{din: {32'h01000003, 32'h00FFFFFF, 32'hFF000000, 32'hFFFFFFFF}, cru: 5'b11100,
                   exp: {32'h4B800002, 32'h4B7FFFFF, 32'hCB800000, 32'hBF800000}};

        // Clock/reset
        rst = 1'b1;
        din = '0;
        cru = 5'b00000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset d_out", d_out, 128'd0);
        check("reset vld_out", {127'd0, vld_out}, 128'd0);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i);
        end

        // Three back-to-back issues give three consecutive pulses in order.
        @(negedge clk);
        din = tbl[0].din; cru = tbl[0].cru;
        @(negedge clk);
        din = tbl[8].din; cru = tbl[8].cru;
        @(negedge clk);
        din = tbl[6].din; cru = tbl[6].cru;
        @(negedge clk);
        cru = 5'b00000;
        check("b2b first vld", {127'd0, vld_out}, 128'd1);
        check("b2b first d_out", d_out, tbl[0].exp);
        @(negedge clk);
        check("b2b second vld", {127'd0, vld_out}, 128'd1);
        check("b2b second d_out", d_out, tbl[8].exp);
        @(negedge clk);
        check("b2b third vld", {127'd0, vld_out}, 128'd1);
        check("b2b third d_out", d_out, tbl[6].exp);

        // Bubble with live-looking data must leave the output untouched.
        @(negedge clk);
        din = {$urandom, $urandom, $urandom, $urandom};
        cru = 5'b01100;
        check("b2b end vld", {127'd0, vld_out}, 128'd0);
        @(negedge clk);
        cru = 5'b00000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bubble%0d vld", k), {127'd0, vld_out}, 128'd0);
            check($sformatf("bubble%0d hold", k), d_out, tbl[6].exp);
        end

        // Reset one cycle after a valid issue kills the instruction.
        @(negedge clk);
        din = tbl[1].din; cru = tbl[1].cru;
        @(negedge clk);
        cru = 5'b00000;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_kill vld0", {127'd0, vld_out}, 128'd0);
        check("rst_kill d_out0", d_out, 128'd0);
        @(negedge clk);
        check("rst_kill vld1", {127'd0, vld_out}, 128'd0);
        check("rst_kill d_out1", d_out, 128'd0);
        @(negedge clk);
        check("rst_kill vld2", {127'd0, vld_out}, 128'd0);

        // Reset asserted together with an issue: reset wins.
        @(negedge clk);
        din = tbl[0].din; cru = tbl[0].cru; rst = 1'b1;
        @(negedge clk);
        cru = 5'b00000; rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_same_cycle vld", {127'd0, vld_out}, 128'd0);
        end
        check("rst_same_cycle d_out", d_out, 128'd0);

        run_vec(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
